// File: rtl/ram_dump_uart_pkg.sv
// Shared types and constants for the RAM dump path and its UART byte serialiser.
package ram_dump_uart_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] dump_state_t;

  localparam dump_state_t IDLE    = 3'd0;
  localparam dump_state_t READ    = 3'd1;
  localparam dump_state_t LATCH   = 3'd2;
  localparam dump_state_t SEND_HI = 3'd3;
  localparam dump_state_t SEND_LO = 3'd4;
  localparam dump_state_t DONE    = 3'd5;

  localparam logic        UART_START      = 1'b0;
  localparam logic        UART_STOP       = 1'b1;
  localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/ram_dump_uart_if.sv
// Read port between the dump engine (master) and the data RAM (slave).
interface ram_dump_uart_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16
);

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_data;

  modport master (output ram_addr, output ram_rd_en, input ram_data);
  modport slave  (input ram_addr, input ram_rd_en, output ram_data);

endinterface

// File: rtl/ram_dump_uart_tx_byte.sv
// 8N1 UART transmitter for one byte; ready rises in the last stop-bit cycle so
// a following start produces a gapless next frame.
module uart_tx_byte
  import ram_dump_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        BIT_STOP  = 4'(UART_FRAME_BITS - 1);
  localparam logic [3:0]        BIT_D7    = 4'(UART_FRAME_BITS - 2);

  logic              r_active;
  logic [BAUD_W-1:0] r_baud;
  logic [3:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_ready;

  // Bit sequencer: start, 8 data bits LSB first, stop; each bit CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= UART_STOP;
      r_ready  <= 1'b1;
    end else if (start && r_ready) begin
      r_active <= 1'b1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= data;
      r_tx     <= UART_START;
      r_ready  <= 1'b0;
    end else if (r_active) begin
      if (r_baud == BAUD_LAST) begin
        r_baud <= '0;
        if (r_bit == BIT_STOP) begin
          r_active <= 1'b0;
          r_bit    <= '0;
        end else begin
          r_bit <= r_bit + 4'd1;
          if (r_bit == BIT_D7) begin
            r_tx <= UART_STOP;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
        if ((r_bit == BIT_STOP) && (r_baud == BAUD_PRE)) begin
          r_ready <= 1'b1;
        end
      end
    end
  end

  assign tx    = r_tx;
  assign ready = r_ready;

endmodule

// File: rtl/ram_dump_uart.sv
// After a CPU end-of-execution edge, reads RAM words 0..DEPTH-1 and sends each
// over UART as two bytes, high byte first.
module ram_dump_uart
  import ram_dump_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DEPTH        = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   eoe,
  ram_dump_uart_if.master        ram,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dump_state_t       r_state, w_state_nxt;
  logic              r_eoe_q;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic [7:0]        r_lo, w_lo_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_trig;
  logic              w_start;
  logic [7:0]        w_byte;
  logic              w_ready;
  logic              w_tx;

  assign w_trig = eoe & ~r_eoe_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_eoe_q <= 1'b0;
      r_addr  <= '0;
      r_rd_en <= 1'b0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_eoe_q <= eoe;
      r_addr  <= w_addr_nxt;
      r_rd_en <= w_rd_en_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state; the high byte is launched straight from RAM data during LATCH,
  // and only the low byte is kept for the second frame.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rd_en_nxt = 1'b0;
    w_lo_nxt    = r_lo;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_start     = 1'b0;
    w_byte      = r_lo;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_nxt = READ;
          w_addr_nxt  = '0;
          w_rd_en_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end
      READ: begin
        w_state_nxt = LATCH;
      end
      LATCH: begin
        w_lo_nxt    = ram.ram_data[7:0];
        w_byte      = ram.ram_data[DATA_W-1 -: 8];
        w_start     = 1'b1;
        w_state_nxt = SEND_HI;
      end
      SEND_HI: begin
        if (w_ready) begin
          w_start     = 1'b1;
          w_state_nxt = SEND_LO;
        end
      end
      SEND_LO: begin
        if (w_ready) begin
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = DONE;
          end else begin
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_rd_en_nxt = 1'b1;
            w_state_nxt = READ;
          end
        end
      end
      DONE: begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .data  (w_byte),
    .tx    (w_tx),
    .ready (w_ready)
  );

  assign ram.ram_addr  = r_addr;
  assign ram.ram_rd_en = r_rd_en;
  assign tx            = w_tx;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_ram_dump_uart.sv
// Bench for ram_dump_uart: RAM model, UART byte monitor and a cycle-level
// waveform model derived from frame arithmetic.
module tb_ram_dump_uart;

  localparam int unsigned CPB      = 4;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int          FRAME    = 10 * CPB;
  localparam int          WORD_CYC = 20 * CPB + 2;
  localparam int          DUMP_CYC = DEPTH * WORD_CYC + 1;
  localparam int          NCYC     = 360;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic eoe   = 1'b0;
  logic tx, busy, done;

  ram_dump_uart_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

  ram_dump_uart #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .eoe   (eoe),
    .ram   (ram_if),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // RAM with one-cycle read latency
  logic [15:0] mem [64];
  always @(posedge clk) if (ram_if.ram_rd_en) ram_if.ram_data <= mem[ram_if.ram_addr];

  // UART receiver sampling mid-bit on falling edges
  logic [7:0] rx_q [$];
  int framing_err = 0;
  initial begin : uart_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset && tx === 1'b0) begin
        repeat (CPB + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) framing_err++;
        rx_q.push_back(b);
      end
    end
  end

  // Observation record of one dump; index n = posedges since eoe was raised.
  logic obs_tx   [NCYC+1];
  logic obs_busy [NCYC+1];
  logic obs_done [NCYC+1];
  int   rd_n_q [$];
  int   rd_a_q [$];

  // Expected tx level n posedges after eoe rises: 2 idle cycles per word
  // (read, latch) then two 10-bit frames; start bit of word 0 at n=3.
  function automatic logic exp_tx(input int n);
    int t, w, o, b;
    logic [7:0] by;
    if (n < 3) return 1'b1;
    t = n - 3;
    w = t / WORD_CYC;
    o = t % WORD_CYC;
    if (w >= DEPTH || o >= 2 * FRAME) return 1'b1;
    by = (o < FRAME) ? mem[w][15:8] : mem[w][7:0];
    b  = (o % FRAME) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    return (k % 2 == 0) ? mem[k/2][15:8] : mem[k/2][7:0];
  endfunction

  // mode 0: single eoe pulse; 1: eoe held high; 2: pulse plus extra pulses mid-dump
  task automatic capture(input int mode);
    rx_q.delete();
    rd_n_q.delete();
    rd_a_q.delete();
    @(negedge clk);
    eoe = 1'b1;
    for (int n = 1; n <= NCYC; n++) begin
      @(posedge clk);
      #1;
      obs_tx[n]   = tx;
      obs_busy[n] = busy;
      obs_done[n] = done;
      if (ram_if.ram_rd_en === 1'b1) begin
        rd_n_q.push_back(n);
        rd_a_q.push_back(int'(ram_if.ram_addr));
      end
      if (mode == 0) eoe = 1'b0;
      else if (mode == 2) eoe = (n == 50 || n == 120 || n == 121 || n == 200 || n == 300);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b0;
    eoe   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (ram_if.ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", ram_if.ram_rd_en); end
    n_tests++; if (ram_if.ram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", ram_if.ram_addr); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ram_if.ram_rd_en !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_dump_directed();
    logic [7:0] spec_bytes [8];
    int mism = 0, first_bad = -1, busy_cnt = 0, busy_first = -1;
    logic [7:0] got;
    spec_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF};
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0000; mem[3] = 16'hFFFF;
    framing_err = 0;
    capture(0);
    n_tests++; if (rx_q.size() != 8) begin n_fail++; $display("FAIL dir_byte_count: got %0d want 8", rx_q.size()); end
    for (int k = 0; k < 8; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      n_tests++; if (got !== spec_bytes[k]) begin n_fail++; $display("FAIL dir_byte%0d: got %h want %h", k, got, spec_bytes[k]); end
    end
    n_tests++; if (framing_err != 0) begin n_fail++; $display("FAIL dir_framing: got %0d errors want 0", framing_err); end
    for (int n = 1; n <= NCYC; n++) begin
      if (obs_busy[n] === 1'b1) begin busy_cnt++; if (busy_first < 0) busy_first = n; end
      if (obs_tx[n] !== exp_tx(n)) begin mism++; if (first_bad < 0) first_bad = n; end
    end
    n_tests++; if (busy_cnt != DUMP_CYC) begin n_fail++; $display("FAIL dir_busy_len: got %0d want %0d", busy_cnt, DUMP_CYC); end
    n_tests++; if (busy_first != 1) begin n_fail++; $display("FAIL dir_busy_start: got %0d want 1", busy_first); end
    n_tests++; if (obs_done[DUMP_CYC] !== 1'b0 || obs_done[DUMP_CYC+1] !== 1'b1)
      begin n_fail++; $display("FAIL dir_done_edge: got %b%b want 01", obs_done[DUMP_CYC], obs_done[DUMP_CYC+1]); end
    n_tests++; if (mism != 0) begin n_fail++; $display("FAIL dir_tx_wave: %0d bad cycles (first n=%0d) want 0", mism, first_bad); end
    n_tests++; if (rd_n_q.size() != DEPTH) begin n_fail++; $display("FAIL dir_rd_count: got %0d want %0d", rd_n_q.size(), DEPTH); end
    for (int k = 0; k < rd_n_q.size() && k < DEPTH; k++) begin
      n_tests++; if (rd_n_q[k] != 1 + k * WORD_CYC || rd_a_q[k] != k)
        begin n_fail++; $display("FAIL dir_rd%0d: got n=%0d addr=%0d want n=%0d addr=%0d", k, rd_n_q[k], rd_a_q[k], 1 + k * WORD_CYC, k); end
    end
  endtask

  task automatic test_hold_eoe();
    int busy_cnt = 0;
    mem[0] = 16'h0F0F; mem[1] = 16'h8001; mem[2] = 16'h5AA5; mem[3] = 16'h7E81;
    capture(1);
    for (int n = 1; n <= NCYC; n++) if (obs_busy[n] === 1'b1) busy_cnt++;
    n_tests++; if (rd_n_q.size() != DEPTH) begin n_fail++; $display("FAIL hold_rd_count: got %0d want %0d", rd_n_q.size(), DEPTH); end
    n_tests++; if (busy_cnt != DUMP_CYC) begin n_fail++; $display("FAIL hold_busy_len: got %0d want %0d", busy_cnt, DUMP_CYC); end
    n_tests++; if (rx_q.size() != 2 * DEPTH) begin n_fail++; $display("FAIL hold_byte_count: got %0d want %0d", rx_q.size(), 2 * DEPTH); end
    @(negedge clk);
    eoe = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_done_kept: got done=%b busy=%b want 1 0", done, busy); end
    capture(0);
    n_tests++; if (obs_done[1] !== 1'b0 || obs_busy[1] !== 1'b1)
      begin n_fail++; $display("FAIL retrig_flags: got done=%b busy=%b want 0 1", obs_done[1], obs_busy[1]); end
    n_tests++; if (rx_q.size() != 2 * DEPTH) begin n_fail++; $display("FAIL retrig_byte_count: got %0d want %0d", rx_q.size(), 2 * DEPTH); end
    for (int k = 0; k < rx_q.size() && k < 2 * DEPTH; k++) begin
      n_tests++; if (rx_q[k] !== exp_byte(k)) begin n_fail++; $display("FAIL retrig_byte%0d: got %h want %h", k, rx_q[k], exp_byte(k)); end
    end
  endtask

  task automatic test_extra_pulses();
    int busy_cnt = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    capture(2);
    for (int n = 1; n <= NCYC; n++) if (obs_busy[n] === 1'b1) busy_cnt++;
    n_tests++; if (rx_q.size() != 2 * DEPTH) begin n_fail++; $display("FAIL extra_byte_count: got %0d want %0d", rx_q.size(), 2 * DEPTH); end
    n_tests++; if (rd_n_q.size() != DEPTH) begin n_fail++; $display("FAIL extra_rd_count: got %0d want %0d", rd_n_q.size(), DEPTH); end
    for (int k = 0; k < rd_a_q.size() && k < DEPTH; k++) begin
      n_tests++; if (rd_a_q[k] != k) begin n_fail++; $display("FAIL extra_rd_addr%0d: got %0d want %0d", k, rd_a_q[k], k); end
    end
    n_tests++; if (busy_cnt != DUMP_CYC) begin n_fail++; $display("FAIL extra_busy_len: got %0d want %0d", busy_cnt, DUMP_CYC); end
  endtask

  task automatic test_reset_mid_dump();
    int bad = 0;
    int stop_n = 3 + 2 * WORD_CYC + 3 * CPB + 1;
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0000; mem[3] = 16'hFFFF;
    @(negedge clk);
    eoe = 1'b1;
    for (int n = 1; n <= stop_n; n++) begin
      @(posedge clk);
      #1;
      eoe = 1'b0;
    end
    n_tests++; if (tx !== exp_tx(stop_n) || busy !== 1'b1)
      begin n_fail++; $display("FAIL mid_pre: got tx=%b busy=%b want tx=%b busy=1", tx, busy, exp_tx(stop_n)); end
    reset = 1'b0;
    #1;
    n_tests++; if (tx !== 1'b1 || busy !== 1'b0 || ram_if.ram_rd_en !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset: got tx=%b busy=%b rd_en=%b want 1 0 0", tx, busy, ram_if.ram_rd_en); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || ram_if.ram_rd_en !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mid_no_replay: %0d bad cycles want 0", bad); end
    capture(0);
    n_tests++; if (rd_a_q.size() == 0 || rd_a_q[0] != 0)
      begin n_fail++; $display("FAIL mid_restart_addr: got %0d pulses first=%0d want first=0", rd_a_q.size(), (rd_a_q.size() > 0) ? rd_a_q[0] : -1); end
    n_tests++; if (rx_q.size() != 2 * DEPTH) begin n_fail++; $display("FAIL mid_byte_count: got %0d want %0d", rx_q.size(), 2 * DEPTH); end
  endtask

  task automatic test_random_timing();
    for (int r = 0; r < 3; r++) begin
      int mism = 0, first_bad = -1, first_low = -1;
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
      capture(0);
      for (int n = 1; n <= NCYC; n++) begin
        if (obs_tx[n] !== exp_tx(n)) begin mism++; if (first_bad < 0) first_bad = n; end
        if (obs_tx[n] === 1'b0 && first_low < 0) first_low = n;
      end
      n_tests++; if (first_low != 3) begin n_fail++; $display("FAIL rnd%0d_first_start: got n=%0d want 3", r, first_low); end
      n_tests++; if (mism != 0) begin n_fail++; $display("FAIL rnd%0d_tx_wave: %0d bad cycles (first n=%0d) want 0", r, mism, first_bad); end
      n_tests++; if (rx_q.size() != 2 * DEPTH) begin n_fail++; $display("FAIL rnd%0d_byte_count: got %0d want %0d", r, rx_q.size(), 2 * DEPTH); end
      for (int k = 0; k < rx_q.size() && k < 2 * DEPTH; k++) begin
        n_tests++; if (rx_q[k] !== exp_byte(k)) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h want %h", r, k, rx_q[k], exp_byte(k)); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    test_reset();
    test_dump_directed();
    test_hold_eoe();
    test_extra_pulses();
    test_reset_mid_dump();
    test_random_timing();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
